// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding memory target with programmable wait and byte-lane writes
module mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         IDX_W    = ADDR_BITS - 2;
    localparam int         WORDS    = 1 << IDX_W;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [WORDS];

    // Request seen by the commit logic: live inputs in IDLE (zero-wait path),
    // the latched copy otherwise.
    logic             c_wr;
    logic [31:0]      c_addr;
    logic [31:0]      c_wdata;
    logic [3:0]       c_be;
    logic [IDX_W-1:0] c_idx;
    logic             c_be_ok;
    logic             c_err;
    logic             commit;
    logic             mem_we;

    // Select the request being committed and evaluate its error conditions
    always_comb begin
        c_wr    = wr_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        c_be    = be_q;
        if (state_q == S_IDLE) begin
            c_wr    = req_wr;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_be    = req_be;
        end
        c_idx = c_addr[ADDR_BITS-1:2];
        case (c_be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: c_be_ok = 1'b1;
            default:                   c_be_ok = 1'b0;
        endcase
        c_err = ((c_addr >> ADDR_BITS) != 32'd0) || !c_be_ok;
    end

    // Next-state, wait counter, request latch and response capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = CNT_LOAD;
                    if (LATENCY == 1) begin
                        commit  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    commit  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (commit) begin
            err_d   = c_err;
            rdata_d = (c_err || c_wr) ? 32'd0 : mem_q[c_idx];
        end
        mem_we = commit && c_wr && !c_err;
    end

    // Control and response registers; reset wins over every other update
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Backing store: not cleared by reset, but a reset edge blocks a pending commit
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) begin
                    mem_q[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed scoreboard bench for mem_responder
module tb_mem_responder;

    localparam int LAT_A = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        reset, req_valid, req_ready, req_wr, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_be;

    logic        reset_b, req_valid_b, req_ready_b, req_wr_b, resp_valid_b, resp_ready_b, resp_err_b;
    logic [31:0] req_addr_b, req_wdata_b, resp_rdata_b;
    logic [3:0]  req_be_b;

    mem_responder #(.ADDR_BITS(8), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut_b (
        .clk(clk), .reset(reset_b),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_wr(req_wr_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b), .req_be(req_be_b),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b)
    );

    logic [31:0] model [64];
    logic [31:0] exp_rd_q [$];
    logic        exp_err_q [$];
    logic [31:0] exp_b_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
            $error("%s", tag);
        end
    endtask

    function automatic logic be_ok(input logic [3:0] be);
        return (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) || (be == 4'b1000) ||
               (be == 4'b0011) || (be == 4'b1100) || (be == 4'b1111);
    endfunction

    task automatic push_exp(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be);
        logic        err;
        logic [31:0] w;
        err = (addr[31:8] != 24'd0) || !be_ok(be);
        exp_err_q.push_back(err);
        exp_rd_q.push_back((err || wr) ? 32'd0 : model[addr[7:2]]);
        if (!err && wr) begin
            w = model[addr[7:2]];
            for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
            model[addr[7:2]] = w;
        end
    endtask

    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold, input string tag);
        int          n;
        logic [31:0] e_rd;
        logic        e_err;
        @(negedge clk);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = be;
        resp_ready = 1'b0;
        push_exp(wr, addr, wdata, be);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(LAT_A - 1));
        e_rd  = exp_rd_q.pop_front();
        e_err = exp_err_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
            chk({tag, "_hold_rdata"}, resp_rdata, e_rd);
            chk({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
            req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h10;
            req_wdata = 32'h0BAD0BAD; req_be = 4'hF;
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({tag, "_rdata"}, resp_rdata, e_rd);
        chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, e_err});
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, "_done_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    function automatic logic [31:0] bdata(input int k);
        return 32'hB000_0000 + 32'(k) * 32'h0101;
    endfunction

    initial begin
        int idx, last_acc, got;
        reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        req_be = '0; resp_ready = 1'b0;
        reset_b = 1'b1; req_valid_b = 1'b0; req_wr_b = 1'b0; req_addr_b = '0;
        req_wdata_b = '0; req_be_b = '0; resp_ready_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; reset_b = 1'b0;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "wr10");
        do_req(1'b0, 32'h10, 32'h0, 4'hF, 0, "rd10");
        do_req(1'b0, 32'h10, 32'h0, 4'b0001, 0, "rd10_lane");

        do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 0, "wr20");
        do_req(1'b1, 32'h20, 32'h0000AA00, 4'b0010, 0, "wr20_b1");
        do_req(1'b1, 32'h20, 32'h55660000, 4'b1100, 0, "wr20_hi");
        do_req(1'b0, 32'h20, 32'h0, 4'hF, 0, "rd20");
        chk("partial_model", model[8], 32'h5566AA44);

        do_req(1'b1, 32'h00, 32'h01020304, 4'hF, 0, "wr00");
        do_req(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 0, "err_range");
        do_req(1'b1, 32'h00, 32'hFFFFFFFF, 4'b0101, 0, "err_be0101");
        do_req(1'b1, 32'h00, 32'hFFFFFFFF, 4'b0000, 0, "err_be0000");
        do_req(1'b0, 32'h200, 32'h0, 4'hF, 0, "err_rd_range");
        do_req(1'b0, 32'h00, 32'h0, 4'hF, 0, "rd00");

        do_req(1'b0, 32'h10, 32'h0, 4'hF, 5, "bp");
        do_req(1'b0, 32'h10, 32'h0, 4'hF, 0, "bp_after");

        do_req(1'b1, 32'h30, 32'h0, 4'hF, 0, "wr30_zero");
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rw_wait_valid", {31'd0, resp_valid}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rw_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rw_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rw_rdata", resp_rdata, 32'd0);
        chk("rw_err", {31'd0, resp_err}, 32'd0);
        do_req(1'b0, 32'h30, 32'h0, 4'hF, 0, "rd30");

        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h34; req_wdata = 32'h12345678; req_be = 4'hF;
        push_exp(1'b1, 32'h34, 32'h12345678, 4'hF);
        void'(exp_rd_q.pop_front());
        void'(exp_err_q.pop_front());
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rr_in_resp", {31'd0, resp_valid}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rr_dropped", {31'd0, resp_valid}, 32'd0);
        do_req(1'b0, 32'h34, 32'h0, 4'hF, 0, "rd34");

        idx = 0; last_acc = -1; got = 0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            chk("b_excl", {31'd0, req_ready_b && resp_valid_b}, 32'd0);
            if (resp_valid_b) begin
                if (exp_b_q.size() == 0) begin
                    chk("b_unexpected_resp", 32'd1, 32'd0);
                end else begin
                    chk("b_rdata", resp_rdata_b, exp_b_q.pop_front());
                end
                chk("b_err", {31'd0, resp_err_b}, 32'd0);
                got++;
            end
            if (idx < 8) begin
                req_valid_b = 1'b1;
                req_wr_b    = (idx < 4);
                req_addr_b  = 32'(4 * (idx % 4));
                req_wdata_b = (idx < 4) ? bdata(idx) : 32'h0;
                req_be_b    = 4'hF;
                if (req_ready_b) begin
                    exp_b_q.push_back((idx < 4) ? 32'd0 : bdata(idx - 4));
                    if (last_acc >= 0) chk("b_gap", 32'(cyc - last_acc), 32'd2);
                    last_acc = cyc;
                    idx++;
                end
            end else begin
                req_valid_b = 1'b0;
            end
        end
        chk("b_resp_count", 32'(got), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
